// File: rtl/alu_pkg.sv
// Shared ALU-side types and sizing for the operand fetch stage.
// Operand forwarding is selected at build time by OPERAND_BYPASS_EN.
package alu_pkg;

  localparam int DATA_W = 16;
  localparam int NREGS  = 8;
  localparam int ADDR_W = $clog2(NREGS);

  typedef logic [1:0]        alu_op_t;
  typedef logic [ADDR_W-1:0] reg_idx_t;
  typedef logic [DATA_W-1:0] data_t;

  localparam alu_op_t OP_ADD = 2'b00;
  localparam alu_op_t OP_SUB = 2'b01;
  localparam alu_op_t OP_AND = 2'b10;
  localparam alu_op_t OP_OR  = 2'b11;

endpackage

// File: rtl/operand_fetch_if.sv
// Issue, write-back and ALU-operand signals of the operand fetch stage.
// master drives issue/write-back/out_ready; slave is the stage itself.
interface operand_fetch_if;
  import alu_pkg::*;

  logic     in_valid;
  logic     in_ready;
  alu_op_t  in_op;
  reg_idx_t in_rs_a;
  reg_idx_t in_rs_b;
  reg_idx_t in_rd;
  logic     in_use_imm;
  data_t    in_imm;

  logic     wb_en;
  reg_idx_t wb_addr;
  data_t    wb_data;

  logic     out_valid;
  logic     out_ready;
  alu_op_t  ctrl;
  data_t    input_a;
  data_t    input_b;
  reg_idx_t out_rd;

  modport master (
    output in_valid, in_op, in_rs_a, in_rs_b, in_rd, in_use_imm, in_imm,
    output wb_en, wb_addr, wb_data, out_ready,
    input  in_ready, out_valid, ctrl, input_a, input_b, out_rd
  );

  modport slave (
    input  in_valid, in_op, in_rs_a, in_rs_b, in_rd, in_use_imm, in_imm,
    input  wb_en, wb_addr, wb_data, out_ready,
    output in_ready, out_valid, ctrl, input_a, input_b, out_rd
  );

endinterface

// File: rtl/operand_fetch_regfile.sv
// General register file: two combinational read ports, one synchronous
// write port, R0 hardwired to zero.
module operand_fetch_regfile
  import alu_pkg::*;
(
  input  logic     clk,
  input  logic     rst_n,
  input  logic     i_wb_en,
  input  reg_idx_t i_wb_addr,
  input  data_t    i_wb_data,
  input  reg_idx_t i_rd_addr_a,
  input  reg_idx_t i_rd_addr_b,
  output data_t    o_rd_data_a,
  output data_t    o_rd_data_b
);

  data_t r_regs [NREGS];

  // Entry 0 is never written; the read mux forces zero regardless.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        r_regs[i] <= '0;
      end
    end else if (i_wb_en && (i_wb_addr != '0)) begin
      r_regs[i_wb_addr] <= i_wb_data;
    end
  end

  assign o_rd_data_a = (i_rd_addr_a == '0) ? '0 : r_regs[i_rd_addr_a];
  assign o_rd_data_b = (i_rd_addr_b == '0) ? '0 : r_regs[i_rd_addr_b];

endmodule

// File: rtl/operand_fetch.sv
// Operand fetch stage ahead of the ALU: register read, immediate select and a
// registered valid/ready output. Define OPERAND_BYPASS_EN for write-first reads.
module operand_fetch
  import alu_pkg::*;
(
  input logic            clk,
  input logic            rst_n,
  operand_fetch_if.slave bus
);

  data_t    w_rf_a;
  data_t    w_rf_b;
  data_t    w_op_a;
  data_t    w_fwd_b;
  data_t    w_op_b;
  logic     w_in_ready;
  logic     w_accept;

  logic     r_out_valid;
  alu_op_t  r_ctrl;
  data_t    r_input_a;
  data_t    r_input_b;
  reg_idx_t r_out_rd;

  operand_fetch_regfile u_regfile (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_wb_en     (bus.wb_en),
    .i_wb_addr   (bus.wb_addr),
    .i_wb_data   (bus.wb_data),
    .i_rd_addr_a (bus.in_rs_a),
    .i_rd_addr_b (bus.in_rs_b),
    .o_rd_data_a (w_rf_a),
    .o_rd_data_b (w_rf_b)
  );

`ifdef OPERAND_BYPASS_EN
  logic w_hit_a;
  logic w_hit_b;

  // A write landing on the same edge as the accept wins over the stored value.
  assign w_hit_a = bus.wb_en && (bus.wb_addr != '0) && (bus.wb_addr == bus.in_rs_a);
  assign w_hit_b = bus.wb_en && (bus.wb_addr != '0) && (bus.wb_addr == bus.in_rs_b);
  assign w_op_a  = w_hit_a ? bus.wb_data : w_rf_a;
  assign w_fwd_b = w_hit_b ? bus.wb_data : w_rf_b;
`else
  assign w_op_a  = w_rf_a;
  assign w_fwd_b = w_rf_b;
`endif

  assign w_op_b     = bus.in_use_imm ? bus.in_imm : w_fwd_b;
  assign w_in_ready = !r_out_valid || bus.out_ready;
  assign w_accept   = bus.in_valid && w_in_ready;

  // Operands are snapshotted at accept; data holds after drain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_ctrl      <= '0;
      r_input_a   <= '0;
      r_input_b   <= '0;
      r_out_rd    <= '0;
    end else if (w_accept) begin
      r_out_valid <= 1'b1;
      r_ctrl      <= bus.in_op;
      r_input_a   <= w_op_a;
      r_input_b   <= w_op_b;
      r_out_rd    <= bus.in_rd;
    end else if (bus.out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.ctrl      = r_ctrl;
  assign bus.input_a   = r_input_a;
  assign bus.input_b   = r_input_b;
  assign bus.out_rd    = r_out_rd;

endmodule

// File: doc/operand_fetch.md
Name: operand_fetch

Overview:
- Pipeline stage directly upstream of the ALU.
- Holds the 8-entry, 16-bit general register file and accepts an issued operation.
- Reads both source operands, optionally substitutes an immediate for operand B, and presents ctrl/input_a/input_b to the ALU from a registered output stage.
- Uses a valid/ready handshake on both sides and accepts the ALU write-back into the register file.

Parameters:
- DATA_W, 16, operand and register width; matches ALU input_a/input_b/alu_result.
- NREGS, 8, number of architectural registers.
- ADDR_W, $clog2(NREGS) = 3, register index width (derived; not overridden).

Ports:
- clk  in  1  single clock; all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  issue request valid.
- in_ready  out  1  stage can accept issue.
- in_op  in  2  ALU operation code; passed to ctrl.
- in_rs_a  in  ADDR_W  source register for operand A.
- in_rs_b  in  ADDR_W  source register for operand B.
- in_rd  in  ADDR_W  destination register, carried to out_rd.
- in_use_imm  in  1  1 = operand B taken from in_imm.
- in_imm  in  DATA_W  immediate value.
- wb_en  in  1  register write enable (ALU result write-back).
- wb_addr  in  ADDR_W  write-back register index.
- wb_data  in  DATA_W  write-back data (alu_result).
- out_valid  out  1  ALU operands valid.
- out_ready  in  1  downstream accepts operands.
- ctrl  out  2  ALU operation.
- input_a  out  DATA_W  ALU operand A.
- input_b  out  DATA_W  ALU operand B.
- out_rd  out  ADDR_W  destination register for the op in flight.

Behaviour:
- Reset: clock is clk; reset rst_n is asynchronous, active-low. While rst_n=0:
  - all registers R0..R7 = 0;
  - out_valid=0, ctrl=0, input_a=0, input_b=0, out_rd=0.
  - Reset mid-transfer drops the held op; no partial state survives.
- in_ready = !out_valid || out_ready. Combinational; never depends on in_valid.
- Accept: in_valid && in_ready at a rising edge.
  - Output register loads ctrl=in_op, input_a=RF[in_rs_a], input_b = in_use_imm ? in_imm : RF[in_rs_b], out_rd=in_rd.
  - out_valid is set to 1.
  - Latency: issue accepted in cycle N, operands visible to the ALU in cycle N+1.
- Drain: out_valid && out_ready with no new accept clears out_valid. Data outputs hold their last values.
- Stall: out_valid && !out_ready holds all outputs stable; in_ready=0.
- Back-to-back: out_ready=1 and in_valid=1 sustain one op per cycle with no bubble.
- Snapshot semantics: operands are captured at accept. Later register writes never alter held outputs.
- Register file:
  - one synchronous write port, two combinational read ports;
  - wb_en writes wb_data to RF[wb_addr] at the edge;
  - writes are independent of the handshake and occur during stalls;
  - R0 always reads 0, and writes to R0 are ignored.
- Same-cycle write and read of the same index (wb_en, wb_addr==rs, accept in the same cycle): result is set by the optional feature below.
- Both rs fields equal: both operands receive the same value.
- in_use_imm=1: RF[in_rs_b] is not used and no forwarding is applied to B.
- Width: no arithmetic in this block; values pass through at DATA_W bits unmodified.

Optional Feature:
- Macro OPERAND_BYPASS_EN.
- Defined: a same-cycle write-back to a nonzero index matching in_rs_a/in_rs_b forwards wb_data into the captured operand (write-first).
- Undefined: the captured operand is the pre-write register value (read-first). The register file still updates at that edge.

Decomposition:
- Package alu_pkg holds:
  - typedef alu_op_t (logic [1:0]) and the ALU op code constants;
  - DATA_W=16, NREGS=8, ADDR_W=3 defaults;
  - typedef reg_idx_t (logic [ADDR_W-1:0]).
- One sub-module regfile: 2 async read ports, 1 sync write port, R0 hardwired, async active-low reset to zero.
- Handshake, immediate mux, bypass and output register live in operand_fetch.

Test Plan:
- Reset:
  - assert rst_n=0 mid-stall with out_valid=1;
  - require out_valid=0 and all outputs 0 immediately, without waiting for a clock edge;
  - after release, reading R1..R7 returns 0.
- Basic issue:
  - wb R1=10, R2=20;
  - issue op=00, rs_a=1, rs_b=2, rd=3;
  - next cycle requires out_valid=1, ctrl=00, input_a=10, input_b=20, out_rd=3.
- Immediate and R0:
  - issue rs_a=0, use_imm=1, imm=30;
  - require input_a=0, input_b=30;
  - write 0x1234 to R0, then read R0 and require 0.
- Stall and snapshot:
  - hold out_ready=0 after issuing rs_a=1 (R1=10);
  - then write R1=99 and present a second issue;
  - require in_ready=0, input_a stays 10, second op not accepted;
  - release out_ready, then second op appears with input_a=99.
- Same-cycle hazard:
  - wb R1=55 in the accept cycle of rs_a=1 (old R1=10);
  - with OPERAND_BYPASS_EN require input_a=55, without require input_a=10;
  - in both builds a later read of R1 returns 55.
- Throughput:
  - out_ready=1, in_valid=1 for 8 cycles with distinct rd 0..7;
  - require 8 consecutive out_valid cycles, out_rd in order, no bubble.
